// File: rtl/rr_arbiter_8_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
package rr_arbiter_8_pkg;

  localparam int NUM_REQ          = 8;
  localparam int IDX_W            = 3;
  localparam int MAX_HOLD_DEFAULT = 16;
  localparam int HOLD_W           = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_arbiter_8_if
  import rr_arbiter_8_pkg::*;
();
  logic               En;
  logic [NUM_REQ-1:0] req;
  logic               done;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               busy;
  logic               timeout;

  modport master (
    output En, req, done,
    input  gnt, gnt_idx, busy, timeout
  );

  modport slave (
    input  En, req, done,
    output gnt, gnt_idx, busy, timeout
  );
endinterface

// File: rtl/rr_arbiter_8_decoder_3x8.sv
// Enabled binary-to-one-hot decoder; one output bit per requester lane.
module decoder_3x8
  import rr_arbiter_8_pkg::*;
(
  input  logic               en,
  input  logic [IDX_W-1:0]   a,
  output logic [NUM_REQ-1:0] y
);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign y[i] = en && (a == IDX_W'(i));
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-way round-robin arbiter with per-grant hold limit and timeout pulse.
// Grants are held until done, request drop, enable drop or the hold limit,
// and every release passes through at least one IDLE cycle.
module rr_arbiter_8
  import rr_arbiter_8_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  rr_arbiter_8_if.slave  bus
);

  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              to_q, to_d;

  logic              win_vld;
  logic [IDX_W-1:0]  win_idx;
  logic [IDX_W-1:0]  cand;
  logic              own_req;
  logic              at_lim;
  logic              release_now;

  // Rotating priority search: first set req bit after last_q, wrapping.
  always_comb begin
    win_vld = 1'b0;
    win_idx = last_q;
    cand    = last_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = last_q + IDX_W'(k);
      if (!win_vld && bus.req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign own_req     = bus.req[idx_q];
  assign at_lim      = (hold_q == HOLD_LIM);
  assign release_now = bus.done || !own_req || !bus.En || at_lim;

  // Next-state logic; timeout only when the hold limit is the sole cause.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    hold_d  = hold_q;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.En && win_vld) begin
          state_d = GRANT;
          idx_d   = win_idx;
          last_d  = win_idx;
          hold_d  = HOLD_W'(1);
        end
      end
      GRANT: begin
        if (release_now) begin
          state_d = IDLE;
          hold_d  = '0;
          to_d    = at_lim && !bus.done && own_req && bus.En;
        end else begin
          hold_d  = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset points the search so requester 0 goes first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      hold_q  <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      to_q    <= to_d;
    end
  end

  assign bus.busy    = (state_q == GRANT);
  assign bus.gnt_idx = idx_q;
  assign bus.timeout = to_q;

  decoder_3x8 u_dec (
    .en (bus.busy),
    .a  (idx_q),
    .y  (bus.gnt)
  );

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed table-driven bench for rr_arbiter_8 plus multi-cycle sequences.
module tb_rr_arbiter_8;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  rr_arbiter_8_if bus ();

  rr_arbiter_8 #(.MAX_HOLD(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic       busy;
    logic [2:0] idx;
    logic       to;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    bus.En   = 1'b1;
    bus.req  = 8'h00;
    bus.done = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic chk_out(input string name, input logic [7:0] g, input logic b,
                         input logic to);
    chk({name, ".gnt"}, bus.gnt, g);
    chk({name, ".busy"}, {7'd0, bus.busy}, {7'd0, b});
    chk({name, ".timeout"}, {7'd0, bus.timeout}, {7'd0, to});
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;

    //            en  req    done gnt    busy idx   to
    tbl[0]  = '{1'b1, 8'h01, 1'b0, 8'h01, 1'b1, 3'd0, 1'b0};
    tbl[1]  = '{1'b1, 8'h01, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0};
    tbl[2]  = '{1'b1, 8'h01, 1'b1, 8'h01, 1'b1, 3'd0, 1'b0};
    tbl[3]  = '{1'b1, 8'h08, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0};
    tbl[4]  = '{1'b1, 8'h08, 1'b0, 8'h08, 1'b1, 3'd3, 1'b0};
    tbl[5]  = '{1'b1, 8'h28, 1'b0, 8'h08, 1'b1, 3'd3, 1'b0};
    tbl[6]  = '{1'b1, 8'h20, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0};
    tbl[7]  = '{1'b1, 8'h20, 1'b0, 8'h20, 1'b1, 3'd5, 1'b0};
    tbl[8]  = '{1'b1, 8'h60, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0};
    tbl[9]  = '{1'b1, 8'h40, 1'b0, 8'h40, 1'b1, 3'd6, 1'b0};
    tbl[10] = '{1'b0, 8'h40, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0};
    tbl[11] = '{1'b0, 8'h40, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0};
    tbl[12] = '{1'b0, 8'h40, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0};
    tbl[13] = '{1'b1, 8'h40, 1'b0, 8'h40, 1'b1, 3'd6, 1'b0};
    tbl[14] = '{1'b1, 8'hC1, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0};
    tbl[15] = '{1'b1, 8'h81, 1'b0, 8'h80, 1'b1, 3'd7, 1'b0};
    tbl[16] = '{1'b1, 8'h81, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0};
    tbl[17] = '{1'b1, 8'h81, 1'b0, 8'h01, 1'b1, 3'd0, 1'b0};
    tbl[18] = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0};
    tbl[19] = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0};

    // Reset state
    rst_n    = 1'b0;
    bus.En   = 1'b0;
    bus.req  = 8'h00;
    bus.done = 1'b0;
    #2;
    chk_out("reset", 8'h00, 1'b0, 1'b0);
    chk("reset.gnt_idx", {5'd0, bus.gnt_idx}, 8'h00);
    tick();
    rst_n = 1'b1;

    // Table of single-cycle vectors
    for (int i = 0; i < 20; i++) begin
      bus.En   = tbl[i].en;
      bus.req  = tbl[i].req;
      bus.done = tbl[i].done;
      tick();
      chk_out($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].busy, tbl[i].to);
      if (tbl[i].busy)
        chk($sformatf("vec%0d.gnt_idx", i), {5'd0, bus.gnt_idx}, {5'd0, tbl[i].idx});
    end

    // All requesting, done each grant: 0..7 then wrap to 0, IDLE between
    do_reset();
    bus.req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      bus.done = 1'b0;
      tick();
      chk($sformatf("rr%0d.gnt", k), bus.gnt, 8'h01 << (k % 8));
      chk($sformatf("rr%0d.gnt_idx", k), {5'd0, bus.gnt_idx}, 8'(k % 8));
      bus.done = 1'b1;
      tick();
      chk($sformatf("rr%0d.gap", k), bus.gnt, 8'h00);
    end
    bus.done = 1'b0;

    // Hold limit: exactly 16 granted cycles, timeout pulse, re-grant
    do_reset();
    bus.req = 8'h10;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk_out($sformatf("hold%0d", k), 8'h10, 1'b1, 1'b0);
    end
    tick();
    chk_out("hold.release", 8'h00, 1'b0, 1'b1);
    tick();
    chk_out("hold.regrant", 8'h10, 1'b1, 1'b0);
    // done coinciding with the limit is a normal release
    for (int k = 0; k < 14; k++) tick();
    chk_out("hold2.c15", 8'h10, 1'b1, 1'b0);
    tick();
    bus.done = 1'b1;
    tick();
    chk_out("hold2.done_at_lim", 8'h00, 1'b0, 1'b0);
    bus.done = 1'b0;
    bus.req  = 8'h00;
    tick();

    // Asynchronous reset mid-grant, then search restarts from requester 0
    do_reset();
    bus.req = 8'h04;
    tick();
    chk_out("mid.grant", 8'h04, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("mid.async", 8'h00, 1'b0, 1'b0);
    chk("mid.gnt_idx", {5'd0, bus.gnt_idx}, 8'h00);
    bus.req = 8'h0C;
    #2;
    rst_n = 1'b1;
    tick();
    chk_out("mid.after", 8'h04, 1'b1, 1'b0);
    chk("mid.after.gnt_idx", {5'd0, bus.gnt_idx}, 8'h02);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_8.md
RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

Interface
REQ-001 Parameter MAX_HOLD, default 16, max consecutive cycles one requester may hold a grant (legal 2..255).
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 En  input  1  arbiter enable; low blocks new grants and revokes the current one.
REQ-005 req  input  8  request vector, bit i = requester i, level-sensitive.
REQ-006 done  input  1  release strobe from current grant owner, one cycle.
REQ-007 gnt  output  8  one-hot grant, all-zero when no owner, registered.
REQ-008 gnt_idx  output  3  binary index of current owner, valid only when busy=1.
REQ-009 busy  output  1  high while a grant is held.
REQ-010 timeout  output  1  one-cycle pulse when a grant is revoked by the MAX_HOLD limit.

Function
REQ-011 Two states SHALL exist: IDLE (gnt=0, busy=0) and GRANT (gnt=one-hot of gnt_idx, busy=1).
REQ-012 IDLE -> GRANT SHALL occur when En=1 and req!=0; grant visible the cycle after req is sampled (latency 1).
REQ-013 Winner SHALL be the first set req bit searching upward from (last_idx+1) mod 8, wrapping 7->0.
REQ-014 last_idx SHALL update to the winner index on the IDLE->GRANT edge only.
REQ-015 In GRANT, gnt and gnt_idx SHALL remain constant regardless of other req bits.
REQ-016 GRANT -> IDLE SHALL occur on the edge after any of: done=1, req[gnt_idx]=0, En=0, hold count reaching MAX_HOLD.
REQ-017 Hold counter SHALL load 1 on grant entry, increment each GRANT cycle, and force release when equal to MAX_HOLD (grant visible exactly MAX_HOLD cycles).
REQ-018 timeout SHALL pulse for one cycle, coincident with the first IDLE cycle, only when release is due solely to the hold limit.
REQ-019 done or req drop in the same cycle as the hold limit SHALL count as normal release (timeout=0).
REQ-020 At least one IDLE cycle (gnt=0) SHALL separate any two grants, including back-to-back grants to different requesters.
REQ-021 done asserted in IDLE SHALL be ignored.
REQ-022 gnt SHALL never have more than one bit set; gnt_idx SHALL equal the encoded gnt whenever busy=1.
REQ-023 Single persistent requester SHALL be re-granted after the mandatory IDLE cycle (round-robin wraps to itself).

Reset
REQ-024 rst_n=0 SHALL immediately force state IDLE, gnt=0, gnt_idx=0, busy=0, timeout=0, hold counter=0, last_idx=7 (first search starts at requester 0).
REQ-025 Reset mid-grant SHALL drop the grant asynchronously with no timeout pulse; first grant after release follows REQ-012 from the next sampled edge.

Structure
REQ-026 Shared package SHALL hold state encoding (IDLE, GRANT), NUM_REQ=8, IDX_W=3 and the default MAX_HOLD.
REQ-027 One sub-module is natural: decoder_3x8 with En tied to busy, converting gnt_idx to gnt; the rotating priority search stays inline.
REQ-028 Hold counter width SHALL be 8 bits; no other arithmetic beyond mod-8 index increment.

Verification
REQ-029 Reset release, req=8'b0000_0001 held -> gnt=8'h01 one cycle after sample, gnt_idx=0, busy=1.
REQ-030 req=8'hFF held, done pulsed each grant -> grant order 0,1,2,...,7,0 with one gnt=0 cycle between each.
REQ-031 req=8'h10 held, never done, MAX_HOLD=16 -> gnt=8'h10 for exactly 16 cycles, then gnt=0 with timeout=1 one cycle, then re-grant 8'h10.
REQ-032 Owner 3 granted, req[3] drops while req[5]=1 -> IDLE next edge, then gnt=8'h20.
REQ-033 En=0 during grant to requester 6 -> gnt=0 next edge, no timeout; req held with En=0 -> no grant until En=1.
REQ-034 rst_n pulsed low mid-grant (owner 2) -> gnt=0 immediately, last_idx=7; after release with req=8'h0C -> gnt=8'h04.
